// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-port bundle between burst requesters, the write arbiter and the FIFO.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DAT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 3
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_WIDTH-1:0] req_len;
  logic [NUM_REQ*DAT_WIDTH-1:0] req_dat;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic [ADDR_WIDTH:0]          fifo_wr_used;
  logic                         fifo_wr_full;
  logic                         fifo_wr_req;
  logic [DAT_WIDTH-1:0]         fifo_wr_dat;

  modport master (
    input  req, req_len, req_dat, fifo_wr_used, fifo_wr_full,
    output req_ack, grant, busy, fifo_wr_req, fifo_wr_dat
  );

  modport slave (
    output req, req_len, req_dat, fifo_wr_used, fifo_wr_full,
    input  req_ack, grant, busy, fifo_wr_req, fifo_wr_dat
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter: grants a whole burst only when the FIFO has room for it,
// then streams it unsplit into the FIFO write port.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DAT_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned SETTLE     = 1
) (
  input logic                clk,
  input logic                aclr,
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned IdxW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GapW  = 2;
  localparam int unsigned FreeW = ADDR_WIDTH + 1;
  localparam logic [FreeW-1:0] Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {StIdle, StBurst, StGap} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [IdxW-1:0]      last_q, last_d;

  logic [FreeW-1:0]     free;
  logic [NUM_REQ-1:0]   eligible;
  logic                 any_elig;
  logic [IdxW-1:0]      win_idx;
  logic                 wr_req;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q <= StIdle;
      grant_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
    end
  end

  // Scan from farthest to nearest after last winner so the nearest eligible one overrides.
  always_comb begin
    free     = Capacity - bus.fifo_wr_used;
    any_elig = 1'b0;
    win_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = bus.req[i] && (bus.req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0) &&
                    (32'(bus.req_len[i*LEN_WIDTH +: LEN_WIDTH]) <= 32'(free));
    end
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (eligible[(int'(last_q) + k) % NUM_REQ]) begin
        any_elig = 1'b1;
        win_idx  = IdxW'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (any_elig) begin
          state_d = StBurst;
          grant_d = NUM_REQ'(1) << win_idx;
          cnt_d   = bus.req_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
          last_d  = win_idx;
        end
      end
      StBurst: begin
        if (wr_req) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = StGap;
            grant_d = '0;
            gap_d   = GapW'(SETTLE);
          end
        end
      end
      StGap: begin
        if (gap_q <= GapW'(1)) begin
          state_d = StIdle;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // grant_q is zero outside a burst, so the AND-OR mux also zeroes the write data there.
  always_comb begin
    wr_req          = (state_q == StBurst) && !bus.fifo_wr_full;
    bus.fifo_wr_req = wr_req;
    bus.req_ack     = grant_q & {NUM_REQ{wr_req}};
    bus.grant       = grant_q;
    bus.busy        = (state_q != StIdle);
    bus.fifo_wr_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.fifo_wr_dat = bus.fifo_wr_dat |
                        (bus.req_dat[i*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{grant_q[i]}});
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed grant, write and ack expectations.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic aclr;
  logic [2:0] len_v [4];
  logic [7:0] dat_v [4];
  int n_pass  = 0;
  int n_total = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DAT_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(3)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DAT_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(3), .SETTLE(1)
  ) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus)
  );

  assign bus.req_len = {len_v[3], len_v[2], len_v[1], len_v[0]};
  assign bus.req_dat = {dat_v[3], dat_v[2], dat_v[1], dat_v[0]};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0;
    aclr = 1'b1;
    #2;
    aclr = 1'b0;
    #1;
  endtask

  initial begin
    int  w;
    logic full_now;
    logic [31:0] seen_grant, seen_ack, seen_busy;

    aclr             = 1'b1;
    bus.req          = '0;
    bus.fifo_wr_used = '0;
    bus.fifo_wr_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      len_v[i] = '0;
      dat_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_wr_req", 32'(bus.fifo_wr_req), 0);
    check("rst_ack", 32'(bus.req_ack), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_dat", 32'(bus.fifo_wr_dat), 0);
    aclr = 1'b0;

    // Single len-3 burst from requester 0 into an empty FIFO.
    len_v[0] = 3'd3;
    dat_v[0] = 8'hA1;
    bus.req  = 4'b0001;
    #1;
    check("t1_idle_grant", 32'(bus.grant), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t1_grant", 32'(bus.grant), 'b0001);
      check("t1_wr_req", 32'(bus.fifo_wr_req), 1);
      check("t1_dat", 32'(bus.fifo_wr_dat), 'hA1 + k);
      check("t1_ack", 32'(bus.req_ack), 'b0001);
      tick();
      dat_v[0] = 8'(8'hA1 + k + 1);
      if (k == 2) bus.req = '0;
      #1;
    end
    check("t1_gap_grant", 32'(bus.grant), 0);
    check("t1_gap_wr_req", 32'(bus.fifo_wr_req), 0);
    check("t1_gap_busy", 32'(bus.busy), 1);
    tick();
    check("t1_idle_busy", 32'(bus.busy), 0);

    // Four requesters, len 2 each: round-robin 0,1,2,3,0 with a 4-cycle start period.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      len_v[i] = 3'd2;
      dat_v[i] = 8'(8'h10 + i);
    end
    bus.req = 4'b1111;
    #1;
    for (int b = 0; b < 5; b++) begin
      tick();
      check("t2_grant", 32'(bus.grant), 1 << (b % 4));
      check("t2_dat", 32'(bus.fifo_wr_dat), 'h10 + (b % 4));
      check("t2_wr1", 32'(bus.fifo_wr_req), 1);
      tick();
      check("t2_wr2", 32'(bus.fifo_wr_req), 1);
      check("t2_ack2", 32'(bus.req_ack), 1 << (b % 4));
      tick();
      check("t2_gap_grant", 32'(bus.grant), 0);
      check("t2_gap_busy", 32'(bus.busy), 1);
      tick();
      check("t2_idle_busy", 32'(bus.busy), 0);
    end

    // Only two words free: len-3 req0 skipped, len-2 req1 granted; req0 once a third frees up.
    do_reset();
    bus.fifo_wr_used = 5'd14;
    len_v[0] = 3'd3;
    len_v[1] = 3'd2;
    dat_v[0] = 8'h30;
    dat_v[1] = 8'h31;
    bus.req  = 4'b0011;
    #1;
    tick();
    check("t3_grant1", 32'(bus.grant), 'b0010);
    check("t3_wr1", 32'(bus.fifo_wr_req), 1);
    tick();
    check("t3_wr2", 32'(bus.fifo_wr_req), 1);
    check("t3_dat2", 32'(bus.fifo_wr_dat), 'h31);
    tick();
    bus.req = 4'b0001;
    #1;
    check("t3_gap_busy", 32'(bus.busy), 1);
    tick();
    check("t3_blocked_a", 32'(bus.busy), 0);
    tick();
    check("t3_blocked_b", 32'(bus.grant), 0);
    bus.fifo_wr_used = 5'd13;
    #1;
    tick();
    check("t3_grant0", 32'(bus.grant), 'b0001);
    check("t3_dat0", 32'(bus.fifo_wr_dat), 'h30);

    // FIFO full for two cycles mid-burst of len 4: burst stretches to 6 cycles.
    do_reset();
    bus.fifo_wr_used = '0;
    len_v[0] = 3'd4;
    dat_v[0] = 8'h40;
    bus.req  = 4'b0001;
    w = 0;
    #1;
    tick();
    for (int c = 0; c < 6; c++) begin
      full_now = (c == 2 || c == 3);
      bus.fifo_wr_full = full_now;
      #1;
      check("t4_grant", 32'(bus.grant), 'b0001);
      check("t4_wr_req", 32'(bus.fifo_wr_req), full_now ? 0 : 1);
      check("t4_ack", 32'(bus.req_ack), full_now ? 0 : 1);
      check("t4_dat", 32'(bus.fifo_wr_dat), 'h40 + w);
      tick();
      if (!full_now) w++;
      dat_v[0] = 8'(8'h40 + w);
      if (w == 4) bus.req = '0;
    end
    bus.fifo_wr_full = 1'b0;
    #1;
    check("t4_gap_grant", 32'(bus.grant), 0);
    check("t4_gap_busy", 32'(bus.busy), 1);
    tick();
    check("t4_idle_busy", 32'(bus.busy), 0);

    // aclr after the 2nd word of a len-5 burst; pointer restarts so req1 beats req2 again.
    do_reset();
    len_v[1] = 3'd5;
    len_v[2] = 3'd1;
    dat_v[1] = 8'h51;
    dat_v[2] = 8'h52;
    bus.req  = 4'b0110;
    #1;
    tick();
    check("t5_grant", 32'(bus.grant), 'b0010);
    tick();
    tick();
    aclr = 1'b1;
    #1;
    check("t5_rst_grant", 32'(bus.grant), 0);
    check("t5_rst_wr_req", 32'(bus.fifo_wr_req), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_ack", 32'(bus.req_ack), 0);
    aclr = 1'b0;
    #1;
    tick();
    check("t5_regrant", 32'(bus.grant), 'b0010);

    // Zero-length request is never granted.
    do_reset();
    len_v[1] = 3'd0;
    bus.req  = 4'b0010;
    seen_grant = 0;
    seen_ack   = 0;
    seen_busy  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      seen_grant = seen_grant | 32'(bus.grant);
      seen_ack   = seen_ack | 32'(bus.req_ack);
      seen_busy  = seen_busy | 32'(bus.busy);
    end
    check("t6_grant", seen_grant, 0);
    check("t6_ack", seen_ack, 0);
    check("t6_busy", seen_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
